// File: rtl/g_reg_wb_arbiter.sv
// Writeback arbiter in front of the general-register cells: two buffered producers,
// round-robin selection, one registered one-hot strobe plus shared data per cycle.
module g_reg_wb_arbiter #(
  parameter int W_OPR   = 32,
  parameter int N_REG   = 32,
  parameter int W_RADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               src0_valid_i,
  input  logic [W_RADDR-1:0] src0_addr_i,
  input  logic [W_OPR-1:0]   src0_data_i,
  output logic               src0_ready_o,
  input  logic               src1_valid_i,
  input  logic [W_RADDR-1:0] src1_addr_i,
  input  logic [W_OPR-1:0]   src1_data_i,
  output logic               src1_ready_o,
  output logic [N_REG-1:0]   wb_o,
  output logic [W_OPR-1:0]   wb_data_o,
  output logic               busy_o
);

  localparam int NSRC  = 2;
  localparam int DEPTH = 2;

  logic [NSRC-1:0]         vld_in;
  logic [W_RADDR-1:0]      addr_in [NSRC];
  logic [W_OPR-1:0]        data_in [NSRC];

  logic [W_RADDR-1:0]      fifo_addr_q [NSRC][DEPTH];
  logic [W_RADDR-1:0]      fifo_addr_d [NSRC][DEPTH];
  logic [W_OPR-1:0]        fifo_data_q [NSRC][DEPTH];
  logic [W_OPR-1:0]        fifo_data_d [NSRC][DEPTH];
  logic [NSRC-1:0][1:0]    cnt_q, cnt_d;
  logic [NSRC-1:0]         wptr_q, wptr_d;
  logic [NSRC-1:0]         rptr_q, rptr_d;
  logic                    rr_q, rr_d;
  logic [N_REG-1:0]        wb_q, wb_d;
  logic [W_OPR-1:0]        wb_data_q, wb_data_d;

  logic [NSRC-1:0]         ready;
  logic [NSRC-1:0]         nonempty;
  logic [NSRC-1:0]         push;
  logic [NSRC-1:0]         gnt;
  logic                    head_sel;
  logic [W_RADDR-1:0]      head_addr;
  logic [W_OPR-1:0]        head_data;

  function automatic logic [N_REG-1:0] decode_onehot(input logic [W_RADDR-1:0] a);
    logic [N_REG-1:0] oh;
    oh    = '0;
    oh[a] = 1'b1;
    return oh;
  endfunction

  assign vld_in     = {src1_valid_i, src0_valid_i};
  assign addr_in[0] = src0_addr_i;
  assign addr_in[1] = src1_addr_i;
  assign data_in[0] = src0_data_i;
  assign data_in[1] = src1_data_i;

  // Stage 0: handshake and round-robin arbitration on the FIFO heads
  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      ready[s]    = (cnt_q[s] != 2'd2);
      nonempty[s] = (cnt_q[s] != 2'd0);
    end
    push = vld_in & ready;
    rr_d = rr_q;
    if (&nonempty) begin
      // rr_q = 0 favours src0; the pointer only moves when both heads compete
      gnt  = rr_q ? 2'b10 : 2'b01;
      rr_d = ~rr_q;
    end else begin
      gnt = nonempty;
    end
    head_sel  = gnt[1];
    head_addr = fifo_addr_q[head_sel][rptr_q[head_sel]];
    head_data = fifo_data_q[head_sel][rptr_q[head_sel]];
  end

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    for (int s = 0; s < NSRC; s++) begin
      if (push[s]) begin
        fifo_addr_d[s][wptr_q[s]] = addr_in[s];
        fifo_data_d[s][wptr_q[s]] = data_in[s];
      end
      cnt_d[s] = cnt_q[s] + {1'b0, push[s]} - {1'b0, gnt[s]};
    end
    wptr_d = wptr_q ^ push;
    rptr_d = rptr_q ^ gnt;
  end

  // Stage 1: registered writeback strobe and shared data
  always_comb begin
    wb_d      = '0;
    wb_data_d = wb_data_q;
    if (|gnt) begin
      wb_d      = decode_onehot(head_addr);
      wb_data_d = head_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      rr_q      <= 1'b0;
      wb_q      <= '0;
      wb_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rr_q      <= rr_d;
      wb_q      <= wb_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign src0_ready_o = ready[0];
  assign src1_ready_o = ready[1];
  assign wb_o         = wb_q;
  assign wb_data_o    = wb_data_q;
  assign busy_o       = (|cnt_q[0]) | (|cnt_q[1]) | (|wb_q);

endmodule

// File: tb/tb_g_reg_wb_arbiter.sv
// Randomized bench for g_reg_wb_arbiter: queue-based reference model checked every
// cycle, plus directed literal checks for reset, latency, arbitration order and mid-run reset.
`timescale 1ns/1ps
module tb_g_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [4:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        src0_ready_o, src1_ready_o, busy_o;
  logic [31:0] wb_o, wb_data_o;

  g_reg_wb_arbiter #(.W_OPR(32), .N_REG(32), .W_RADDR(5)) dut (
    .clk(clk), .reset(reset),
    .src0_valid_i(v0), .src0_addr_i(a0), .src0_data_i(d0), .src0_ready_o(src0_ready_o),
    .src1_valid_i(v1), .src1_addr_i(a1), .src1_data_i(d1), .src1_ready_o(src1_ready_o),
    .wb_o(wb_o), .wb_data_o(wb_data_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q0[$], q1[$];
  ent_t        e;
  int          m_prio;
  int          gsel;
  int          n0, n1;
  logic [31:0] m_wb, m_data;
  logic        acc0, acc1;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: per-source queues, priority source flips after a contested grant
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q0.delete();
      q1.delete();
      m_prio = 0;
      m_wb   = '0;
      m_data = '0;
      acc0   = 1'b0;
      acc1   = 1'b0;
    end else begin
      n0   = q0.size();
      n1   = q1.size();
      gsel = -1;
      if (n0 > 0 && n1 > 0) begin
        gsel   = m_prio;
        m_prio = 1 - m_prio;
      end else if (n0 > 0) gsel = 0;
      else if (n1 > 0) gsel = 1;
      if (gsel == 0) e = q0.pop_front();
      else if (gsel == 1) e = q1.pop_front();
      if (gsel >= 0) begin
        m_wb   = 32'd1 << e.a;
        m_data = e.d;
      end else begin
        m_wb = '0;
      end
      acc0 = v0 && (n0 < 2);
      acc1 = v1 && (n1 < 2);
      if (acc0) q0.push_back({a0, d0});
      if (acc1) q1.push_back({a1, d1});
    end
  end

  always @(negedge clk) begin
    chk("ready0", {63'd0, src0_ready_o}, {63'd0, q0.size() < 2});
    chk("ready1", {63'd0, src1_ready_o}, {63'd0, q1.size() < 2});
    chk("wb_o", {32'd0, wb_o}, {32'd0, m_wb});
    chk("wb_data", {32'd0, wb_data_o}, {32'd0, m_data});
    chk("busy", {63'd0, busy_o}, {63'd0, (q0.size() != 0) || (q1.size() != 0) || (m_wb != 0)});
  end

  task automatic run_rand(input int n, input int p0, input int p1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!v0 || acc0) begin
        if ($urandom_range(99) < p0) begin
          v0 = 1'b1; a0 = 5'($urandom); d0 = $urandom;
        end else v0 = 1'b0;
      end
      if (!v1 || acc1) begin
        if ($urandom_range(99) < p1) begin
          v1 = 1'b1; a1 = 5'($urandom); d1 = $urandom;
        end else v1 = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (acc0) v0 = 1'b0;
      if (acc1) v1 = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wb", {32'd0, wb_o}, 64'd0);
    chk("rst_data", {32'd0, wb_data_o}, 64'd0);
    chk("rst_ready0", {63'd0, src0_ready_o}, 64'd1);
    chk("rst_ready1", {63'd0, src1_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);

    // single src0 write to register 3
    v0 = 1'b1; a0 = 5'd3; d0 = 32'hDEADBEEF;
    @(negedge clk);
    v0 = 1'b0;
    chk("single_busy_q", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    chk("single_wb", {32'd0, wb_o}, 64'h8);
    chk("single_data", {32'd0, wb_data_o}, 64'hDEADBEEF);
    @(negedge clk);
    chk("single_wb_off", {32'd0, wb_o}, 64'd0);
    chk("single_busy_off", {63'd0, busy_o}, 64'd0);
    chk("single_data_hold", {32'd0, wb_data_o}, 64'hDEADBEEF);

    // contested pair: src0 has priority first
    v0 = 1'b1; a0 = 5'd1; d0 = 32'h11111111;
    v1 = 1'b1; a1 = 5'd9; d1 = 32'h99999999;
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    chk("pair_wb0", {32'd0, wb_o}, 64'd0);
    @(negedge clk);
    chk("pair_wb1", {32'd0, wb_o}, 64'h2);
    chk("pair_d1", {32'd0, wb_data_o}, 64'h11111111);
    @(negedge clk);
    chk("pair_wb2", {32'd0, wb_o}, 64'h200);
    chk("pair_d2", {32'd0, wb_data_o}, 64'h99999999);
    @(negedge clk);
    chk("pair_wb3", {32'd0, wb_o}, 64'd0);

    run_rand(60, 100, 100);
    drain();
    run_rand(60, 100, 0);
    drain();
    run_rand(60, 0, 100);
    drain();
    run_rand(60, 100, 40);
    drain();
    run_rand(200, 35, 35);
    drain();

    // asynchronous reset with both FIFOs loaded and a strobe in flight
    run_rand(12, 100, 100);
    @(posedge clk);
    #2;
    reset = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    #1;
    chk("mid_rst_wb", {32'd0, wb_o}, 64'd0);
    chk("mid_rst_data", {32'd0, wb_data_o}, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_wb", {32'd0, wb_o}, 64'd0);
    chk("post_rst_busy", {63'd0, busy_o}, 64'd0);

    run_rand(80, 60, 60);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
